// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared system bus.
// Grants one master at a time, runs a single-word transfer, and completes it on slave ready or aborts it on timeout.
module bus_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    m_req,
  input  logic [N-1:0]    m_r_w,
  input  logic [32*N-1:0] m_addr,
  input  logic [32*N-1:0] m_wdata,
  output logic [N-1:0]    m_grant,
  output logic [N-1:0]    m_done,
  output logic [N-1:0]    m_err,
  output logic [31:0]     m_rdata,
  output logic [31:0]     bus_address,
  output logic            bus_request,
  output logic            bus_r_w,
  inout  tri   [31:0]     bus_data,
  input  logic            bus_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [N-1:0]    r_done;
  logic [N-1:0]    r_err;
  logic [31:0]     r_rdata;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_request;
  logic            r_r_w;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_last;

  logic [N-1:0]    w_eligible;
  logic            w_found;
  logic [IW-1:0]   w_winner;
  logic [31:0]     w_addr  [N];
  logic [31:0]     w_wdata [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_addr[gi]  = m_addr[32*gi +: 32];
      assign w_wdata[gi] = m_wdata[32*gi +: 32];
    end
  endgenerate

  // A master whose done pulse is high this cycle is still holding m_req; mask it.
  assign w_eligible = m_req & ~r_done;

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && w_eligible[(int'(r_last) + k) % N]) begin
        w_found  = 1'b1;
        w_winner = IW'((int'(r_last) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_request <= 1'b0;
      r_r_w     <= 1'b0;
      r_cnt     <= '0;
      r_last    <= IW'(N - 1);
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant   <= N'(1) << w_winner;
            r_addr    <= w_addr[w_winner];
            r_wdata   <= w_wdata[w_winner];
            r_r_w     <= m_r_w[w_winner];
            r_request <= 1'b1;
            r_cnt     <= '0;
            r_last    <= w_winner;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          // Ready has priority over the timeout on the final cycle.
          if (bus_ready) begin
            if (!r_r_w) begin
              r_rdata <= bus_data;
            end
            r_done    <= r_grant;
            r_grant   <= '0;
            r_request <= 1'b0;
            r_state   <= IDLE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_done    <= r_grant;
            r_err     <= r_grant;
            r_rdata   <= 32'hFFFF_FFFF;
            r_grant   <= '0;
            r_request <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_data    = (r_state == BUSY && r_r_w) ? r_wdata : 32'bz;
  assign m_grant     = r_grant;
  assign m_done      = r_done;
  assign m_err       = r_err;
  assign m_rdata     = r_rdata;
  assign bus_address = r_addr;
  assign bus_request = r_request;
  assign bus_r_w     = r_r_w;

endmodule
